// File: rtl/mips_prog_loader_if.sv
// rtl/mips_prog_loader_if.sv - byte stream input and memory write bus of the program loader
interface mips_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - boot loader: length-prefixed byte frame into word memory with XOR check
module mips_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                start_i,
    mips_prog_loader_if.master  bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                core_run_o,
    output logic [ADDR_W:0]     words_loaded_o
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;

    state_t          state_q;
    logic [7:0]      len_hi_q;
    logic [7:0]      csum_q;
    logic [23:0]     word_q;
    logic [1:0]      bcnt_q;
    logic [ADDR_W:0] len_q;

    logic [15:0]     len_d;
    logic [ADDR_W:0] wcount_d;
    logic            accept;

    always_comb begin
        len_d    = {len_hi_q, bus.byte_in};
        wcount_d = words_loaded_o + 1'b1;
        accept   = bus.byte_valid && bus.byte_ready;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q        <= IDLE;
            len_hi_q       <= '0;
            csum_q         <= '0;
            word_q         <= '0;
            bcnt_q         <= '0;
            len_q          <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            core_run_o     <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state_q)
                // start is only honoured when no load is running; a restart clears all flags
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q        <= LEN_HI;
                        busy_o         <= 1'b1;
                        bus.byte_ready <= 1'b1;
                        done_o         <= 1'b0;
                        err_o          <= 1'b0;
                        core_run_o     <= 1'b0;
                        words_loaded_o <= '0;
                        csum_q         <= '0;
                        bcnt_q         <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= bus.byte_in;
                        state_q  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q <= len_d[ADDR_W:0];
                        if (len_d == 16'd0 || len_d > 16'(DEPTH)) begin
                            state_q        <= ERR;
                            bus.byte_ready <= 1'b0;
                            busy_o         <= 1'b0;
                            err_o          <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q <= {word_q[15:0], bus.byte_in};
                        csum_q <= csum_q ^ bus.byte_in;
                        bcnt_q <= bcnt_q + 2'd1;
                        // word_q already holds the three leading bytes, most significant first
                        if (bcnt_q == 2'd3) begin
                            bus.mem_we     <= 1'b1;
                            bus.mem_addr   <= words_loaded_o[ADDR_W-1:0];
                            bus.mem_wdata  <= {word_q, bus.byte_in};
                            words_loaded_o <= wcount_d;
                            if (wcount_d == len_q) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        bus.byte_ready <= 1'b0;
                        busy_o         <= 1'b0;
                        if (bus.byte_in == csum_q) begin
                            state_q    <= DONE;
                            done_o     <= 1'b1;
                            core_run_o <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_o   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - randomized scoreboard bench for the program loader
module tb_mips_prog_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic            clk1 = 1'b0;
    logic            rst;
    logic            start_i;
    logic            busy_o, done_o, err_o, core_run_o;
    logic [ADDR_W:0] words_loaded_o;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] words[DEPTH];

    mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk1          (clk1),
        .rst           (rst),
        .start_i       (start_i),
        .bus           (bus),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .core_run_o    (core_run_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write must match the oldest outstanding expected write.
    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("write_data", bus.mem_wdata, e.data);
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk1);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(negedge clk1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk1);
        start_i = 1'b0;
    endtask

    // Reference: N legal -> N writes at 0..N-1, checksum = XOR of payload bytes.
    task automatic run_frame(input int n, input bit bad_csum, input int gmin, input int gmax);
        logic [7:0]  csum;
        logic [15:0] len16;
        bit          legal;
        csum  = 8'h00;
        len16 = 16'(n);
        legal = (n >= 1) && (n <= DEPTH);
        pulse_start();
        check("ready_after_start", 32'(bus.byte_ready), 32'd1);
        if (legal)
            for (int k = 0; k < n; k++) exp_q.push_back('{addr: k, data: words[k]});
        send_byte(len16[15:8], $urandom_range(gmax, gmin));
        send_byte(len16[7:0], $urandom_range(gmax, gmin));
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                for (int j = 3; j >= 0; j--) begin
                    logic [7:0] b;
                    b    = 8'(words[k] >> (8 * j));
                    csum = csum ^ b;
                    send_byte(b, $urandom_range(gmax, gmin));
                end
            end
            send_byte(bad_csum ? (csum ^ 8'h01) : csum, $urandom_range(gmax, gmin));
        end
        @(negedge clk1);
        check("done", 32'(done_o), 32'(legal && !bad_csum));
        check("err", 32'(err_o), 32'(!legal || bad_csum));
        check("core_run", 32'(core_run_o), 32'(legal && !bad_csum));
        check("busy", 32'(busy_o), 32'd0);
        check("byte_ready_end", 32'(bus.byte_ready), 32'd0);
        check("words_loaded", 32'(words_loaded_o), legal ? 32'(n) : 32'd0);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        start_i        = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk1);
        rst = 1'b0;
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_core_run", 32'(core_run_o), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);

        words[0] = 32'h8C20000A;
        run_frame(1, 1'b0, 0, 0);
        run_frame(1, 1'b1, 0, 0);

        for (int k = 0; k < 3; k++) words[k] = $urandom;
        run_frame(3, 1'b0, 1, 1);

        run_frame(0, 1'b0, 0, 0);
        run_frame(1025, 1'b0, 0, 0);

        for (int k = 0; k < DEPTH; k++) words[k] = $urandom;
        run_frame(DEPTH, 1'b0, 0, 0);

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(8, 1);
            for (int k = 0; k < n; k++) words[k] = $urandom;
            run_frame(n, ($urandom_range(3, 0) == 0), 0, 3);
        end

        // Reset mid-load after 6 payload bytes of an N=2 frame.
        words[0] = $urandom;
        words[1] = $urandom;
        pulse_start();
        exp_q.push_back('{addr: 0, data: words[0]});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int j = 3; j >= 0; j--) send_byte(8'(words[0] >> (8 * j)), 0);
        send_byte(8'(words[1] >> 24), 0);
        pulse_start();
        check("start_ignored_words", 32'(words_loaded_o), 32'd1);
        check("start_ignored_busy", 32'(busy_o), 32'd1);
        send_byte(8'(words[1] >> 16), 0);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        check("mid_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        check("mid_rst_core_run", 32'(core_run_o), 32'd0);
        check("mid_rst_words", 32'(words_loaded_o), 32'd0);
        check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk1);
        bus.byte_valid = 1'b0;
        check("mid_rst_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        words[0] = $urandom;
        run_frame(1, 1'b0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
